// File: rtl/priority_pkg.sv
// Shared code/one-hot types and constants for the priority encoder/decoder pair.
// Code 2'b00 names the highest-priority request line (bit 3), 2'b11 the lowest (bit 0).
package priority_pkg;

  typedef logic [1:0] code_t;
  typedef logic [3:0] onehot_t;

  localparam code_t CODE_B0 = 2'b11;
  localparam code_t CODE_B1 = 2'b10;
  localparam code_t CODE_B2 = 2'b01;
  localparam code_t CODE_B3 = 2'b00;

  localparam onehot_t OH_B0 = 4'b0001;
  localparam onehot_t OH_B1 = 4'b0010;
  localparam onehot_t OH_B2 = 4'b0100;
  localparam onehot_t OH_B3 = 4'b1000;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_state_t;

  function automatic onehot_t decode_code(input code_t code);
    onehot_t oh;
    oh = OH_B3;
    case (code)
      CODE_B0: oh = OH_B0;
      CODE_B1: oh = OH_B1;
      CODE_B2: oh = OH_B2;
      default: oh = OH_B3;
    endcase
    return oh;
  endfunction

  // Encoder side: the highest set bit wins; an all-zero request maps to CODE_B0.
  function automatic code_t encode_onehot(input onehot_t req);
    code_t code;
    code = CODE_B0;
    if (req[3])      code = CODE_B3;
    else if (req[2]) code = CODE_B2;
    else if (req[1]) code = CODE_B1;
    return code;
  endfunction

endpackage

// File: rtl/priority_dec_if.sv
// Code-in / one-hot-out handshake bundle plus occupancy and delivery-count status.
interface priority_dec_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  import priority_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  code_t              Y;
  logic               valid;
  logic               ready;
  onehot_t            D;
  logic               d_valid;
  logic               d_ready;
  logic [LVL_W-1:0]   level;
  logic [CNT_W-1:0]   count;

  modport master (
    output Y, valid, d_ready,
    input  ready, D, d_valid, level, count
  );

  modport slave (
    input  Y, valid, d_ready,
    output ready, D, d_valid, level, count
  );

endinterface

// File: rtl/priority_dec_code_fifo.sv
// Power-of-two circular queue of 2-bit codes; the caller guarantees push only when
// not full and pop only when not empty.
module code_fifo
  import priority_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  code_t                    wr_data,
  input  logic                     pop,
  output code_t                    rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  code_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;

  // Storage carries no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign level   = level_reg;

endmodule

// File: rtl/priority_dec.sv
// Queued priority-code decoder: accepts 2-bit codes, delivers one-hot words in
// arrival order one cycle later at the earliest, and counts delivered words.
module priority_dec
  import priority_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  priority_dec_if.slave     bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] LVL_ONE       = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL_M1   = LVL_W'(DEPTH - 1);

  occ_state_t        st_reg;
  occ_state_t        st_next;
  logic              ready_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [LVL_W-1:0]  fifo_level;
  code_t             head_code;
  logic              out_valid;
  logic              push;
  logic              pop;

  assign out_valid = (st_reg != ST_EMPTY);
  assign push      = bus.valid & ready_reg;
  assign pop       = out_valid & bus.d_ready;

  code_fifo #(
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (bus.Y),
    .pop     (pop),
    .rd_data (head_code),
    .level   (fifo_level)
  );

  // ready is registered from the next state so d_ready never reaches it combinationally;
  // it also stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_reg    <= ST_EMPTY;
      ready_reg <= 1'b0;
    end else begin
      st_reg    <= st_next;
      ready_reg <= (st_next != ST_FULL);
    end
  end

  always_comb begin
    st_next = st_reg;
    case (st_reg)
      ST_EMPTY: begin
        if (push) st_next = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (push && !pop && fifo_level == LVL_FULL_M1) begin
          st_next = ST_FULL;
        end else if (pop && !push && fifo_level == LVL_ONE) begin
          st_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) st_next = ST_PARTIAL;
      end
      default: st_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (pop) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign bus.ready   = ready_reg;
  assign bus.d_valid = out_valid;
  assign bus.D       = out_valid ? decode_code(head_code) : '0;
  assign bus.level   = fifo_level;
  assign bus.count   = count_reg;

endmodule

// File: tb/tb_priority_dec.sv
// Scoreboard bench for priority_dec: accepted codes queue their expected one-hot word,
// each delivered word is checked against the queue head.
module tb_priority_dec;
  import priority_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;

  priority_dec_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  priority_dec #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] sb_q [$];
  int vectors     = 0;
  int miscompares = 0;
  int pops_total  = 0;

  function automatic logic [3:0] model_dec(input logic [1:0] y);
    case (y)
      2'b11:   return 4'b0001;
      2'b10:   return 4'b0010;
      2'b01:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // One clock: scoreboard bookkeeping just before the edge, then settle after it.
  task automatic cycle();
    logic [3:0] exp_d;
    @(negedge clk);
    if (rst) begin
      if (bus.d_valid && bus.d_ready) begin
        vectors++;
        pops_total++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_underflow: delivered D=%b, required no word", bus.D);
        end else begin
          exp_d = sb_q.pop_front();
          $display("deliver #%0d D=%b expected=%b", pops_total, bus.D, exp_d);
          if (bus.D !== exp_d) begin
            miscompares++;
            $display("FAIL sb_order: D=%b, required %b", bus.D, exp_d);
          end
        end
      end
      if (bus.valid && bus.ready) sb_q.push_back(model_dec(bus.Y));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    bus.valid   = 1'b0;
    bus.d_ready = 1'b1;
    n = 0;
    while (bus.level != 0 && n < 20) begin
      cycle();
      n++;
    end
    vectors++;
    if (bus.level !== 0 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: level=%0d queue=%0d, required 0 and 0", bus.level, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.Y = 2'b00; bus.valid = 1'b0; bus.d_ready = 1'b0;
    #2;
    vectors++;
    if ({bus.D, bus.d_valid, bus.ready, bus.level, bus.count} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: D=%b dv=%b rdy=%b lvl=%0d cnt=%0d, required all 0",
               bus.D, bus.d_valid, bus.ready, bus.level, bus.count);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge: ready=%b, required 0", bus.ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.ready !== 1'b1 || bus.d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_after_release: ready=%b d_valid=%b, required 1 0", bus.ready, bus.d_valid);
    end
  endtask

  task automatic test_decode_sweep();
    logic [1:0] codes [4];
    logic [3:0] exp_oh [4];
    codes  = '{2'b11, 2'b10, 2'b01, 2'b00};
    exp_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bus.d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.Y = codes[i]; bus.valid = 1'b1;
      cycle();
      vectors++;
      if (bus.d_valid !== 1'b1 || bus.D !== exp_oh[i]) begin
        miscompares++;
        $display("FAIL sweep_latency[%0d]: d_valid=%b D=%b, required 1 %b", i, bus.d_valid, bus.D, exp_oh[i]);
      end
    end
    bus.valid = 1'b0;
    cycle();
    vectors++;
    if (bus.count !== 8'd4 || bus.level !== 0) begin
      miscompares++;
      $display("FAIL sweep_count: count=%0d level=%0d, required 4 0", bus.count, bus.level);
    end
  endtask

  task automatic test_fill_backpressure();
    logic [1:0] codes [5];
    codes = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
    bus.d_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.Y = codes[i]; bus.valid = 1'b1;
      cycle();
    end
    vectors++;
    if (bus.level !== 3'd4 || bus.ready !== 1'b0 || bus.D !== 4'b0100) begin
      miscompares++;
      $display("FAIL fill_full: level=%0d ready=%b D=%b, required 4 0 0100", bus.level, bus.ready, bus.D);
    end
    bus.Y = codes[4];
    cycle();
    cycle();
    vectors++;
    if (bus.level !== 3'd4 || bus.d_valid !== 1'b1 || bus.D !== 4'b0100) begin
      miscompares++;
      $display("FAIL fill_hold: level=%0d d_valid=%b D=%b, required 4 1 0100", bus.level, bus.d_valid, bus.D);
    end
    bus.d_ready = 1'b1;
    cycle();
    vectors++;
    if (bus.level !== 3'd3 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_pop: level=%0d ready=%b, required 3 1", bus.level, bus.ready);
    end
    bus.d_ready = 1'b0;
    cycle();
    vectors++;
    if (bus.level !== 3'd4) begin
      miscompares++;
      $display("FAIL fifth_accept: level=%0d, required 4", bus.level);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    bus.d_ready = 1'b0; bus.valid = 1'b1;
    bus.Y = 2'b00; cycle();
    bus.Y = 2'b10; cycle();
    bus.d_ready = 1'b1;
    bus.Y = 2'b11; cycle();
    vectors++;
    if (bus.level !== 3'd2) begin
      miscompares++;
      $display("FAIL simul_level_a: level=%0d, required 2", bus.level);
    end
    bus.Y = 2'b01; cycle();
    vectors++;
    if (bus.level !== 3'd2) begin
      miscompares++;
      $display("FAIL simul_level_b: level=%0d, required 2", bus.level);
    end
    drain();
  endtask

  task automatic test_wrap();
    bus.valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.Y = 2'($urandom_range(0, 3));
      bus.d_ready = (i >= 2);
      cycle();
    end
    vectors++;
    if (bus.level !== 3'd2) begin
      miscompares++;
      $display("FAIL wrap_level: level=%0d, required 2", bus.level);
    end
    drain();
  endtask

  task automatic test_loopback();
    logic [3:0] req;
    logic [3:0] hp;
    bus.valid = 1'b1; bus.d_ready = 1'b1;
    for (int d = 1; d < 16; d++) begin
      req = 4'(d);
      if (req[3])      bus.Y = 2'b00;
      else if (req[2]) bus.Y = 2'b01;
      else if (req[1]) bus.Y = 2'b10;
      else             bus.Y = 2'b11;
      hp = 4'b0000;
      for (int b = 0; b < 4; b++) if (req[b]) hp = 4'b0001 << b;
      cycle();
      vectors++;
      if (bus.D !== hp) begin
        miscompares++;
        $display("FAIL loopback[%b]: D=%b, required %b", req, bus.D, hp);
      end
    end
    drain();
  endtask

  task automatic test_count_wrap();
    bit seen255 = 0;
    bit seen0   = 0;
    bus.valid = 1'b1; bus.d_ready = 1'b1;
    for (int n = 0; n < 600 && !seen0; n++) begin
      bus.Y = 2'($urandom_range(0, 3));
      cycle();
      if (pops_total == 255 && !seen255) begin
        seen255 = 1;
        vectors++;
        if (bus.count !== 8'd255) begin
          miscompares++;
          $display("FAIL count_255: count=%0d, required 255", bus.count);
        end
      end
      if (pops_total == 256) begin
        seen0 = 1;
        vectors++;
        if (bus.count !== 8'd0) begin
          miscompares++;
          $display("FAIL count_wrap: count=%0d, required 0", bus.count);
        end
      end
    end
    vectors++;
    if (!seen0) begin
      miscompares++;
      $display("FAIL count_timeout: pops=%0d, required 256", pops_total);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    bus.d_ready = 1'b0; bus.valid = 1'b1;
    bus.Y = 2'b10; cycle();
    bus.Y = 2'b01; cycle();
    bus.Y = 2'b00; cycle();
    bus.valid = 1'b0;
    vectors++;
    if (bus.level !== 3'd3 || bus.count == 0) begin
      miscompares++;
      $display("FAIL pre_reset: level=%0d count=%0d, required 3 and nonzero", bus.level, bus.count);
    end
    #3;
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.D, bus.d_valid, bus.ready, bus.level, bus.count} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: D=%b dv=%b rdy=%b lvl=%0d cnt=%0d, required all 0",
               bus.D, bus.d_valid, bus.ready, bus.level, bus.count);
    end
    sb_q.delete();
    pops_total = 0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.ready !== 1'b1 || bus.d_valid !== 1'b0 || bus.D !== 4'b0000) begin
      miscompares++;
      $display("FAIL post_release: ready=%b d_valid=%b D=%b, required 1 0 0000", bus.ready, bus.d_valid, bus.D);
    end
    bus.Y = 2'b11; bus.valid = 1'b1;
    cycle();
    vectors++;
    if (bus.D !== 4'b0001 || bus.level !== 3'd1) begin
      miscompares++;
      $display("FAIL post_reset_push: D=%b level=%0d, required 0001 1", bus.D, bus.level);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_fill_backpressure();
    test_simultaneous();
    test_wrap();
    test_loopback();
    test_count_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/priority_dec.md
PRIORITY_DEC -- requirements
Module: priority_dec

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the code-queue depth in entries (power of two, >= 2).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the delivered-word counter.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset, asynchronous and active-low.
REQ-005 The block SHALL have port Y, input, 2 bits, the encoded priority code.
REQ-006 The block SHALL have port valid, input, 1 bit, meaning Y carries a code.
REQ-007 The block SHALL have port ready, output, 1 bit, meaning the block accepts Y this cycle.
REQ-008 The block SHALL have port D, output, 4 bits, the one-hot decoded request.
REQ-009 The block SHALL have port d_valid, output, 1 bit, meaning D is valid.
REQ-010 The block SHALL have port d_ready, input, 1 bit, meaning the consumer takes D this cycle.
REQ-011 The block SHALL have port level, output, clog2(DEPTH)+1 bits, the current queue occupancy.
REQ-012 The block SHALL have port count, output, CNT_W bits, the number of words delivered.

Function
REQ-013 The block SHALL decode Y as follows: 2'b11 -> 4'b0001, 2'b10 -> 4'b0010, 2'b01 -> 4'b0100, 2'b00 -> 4'b1000.
REQ-014 The block SHALL accept a code on a rising edge where valid=1 and ready=1 (push), and ignore Y otherwise.
REQ-015 The block SHALL deliver a word on a rising edge where d_valid=1 and d_ready=1 (pop).
REQ-016 The block SHALL queue accepted codes in FIFO order and deliver them in that order, with none lost or duplicated.
REQ-017 The block SHALL drive ready = (level < DEPTH) from registered state only, with no combinational path from d_ready or valid.
REQ-018 The block SHALL drive d_valid = (level != 0), and D = the decode of the head entry when d_valid=1, else 4'b0000.
REQ-019 The block SHALL give a latency of one cycle: a push into an empty queue at edge N shows d_valid=1 with D decoded after edge N.
REQ-020 The block SHALL, on a simultaneous push and pop, leave level unchanged and place the new entry behind the head.
REQ-021 The block SHALL, when full, hold ready=0 even if d_ready=1 in the same cycle; the slot frees on the next edge.
REQ-022 The block SHALL hold D and d_valid stable while d_valid=1 and d_ready=0.
REQ-023 The block SHALL wrap its read and write pointers modulo DEPTH with no gap at wrap-around.
REQ-024 The block SHALL increment count by 1 on each pop, wrapping 2^CNT_W-1 -> 0, and leave it unchanged otherwise.
REQ-025 The block SHALL derive output state from level only, giving states EMPTY (d_valid=0), PARTIAL, and FULL (ready=0), with transitions by push/pop per REQ-020/021.

Reset
REQ-026 The block SHALL, while rst=0, immediately force D=4'b0000, d_valid=0, ready=0, level=0 and count=0, regardless of clk.
REQ-027 The block SHALL, on reset assertion mid-operation, discard all queued entries; no stale word appears after release.
REQ-028 The block SHALL drive ready=1 from the first clk edge after rst rises.

Structure
REQ-029 The block SHALL take the code typedef (2-bit), the one-hot typedef (4-bit) and the four code/one-hot constants from shared package priority_pkg, which the encoder shares.
REQ-030 The block SHALL place the queue in one sub-module, code_fifo (parameterised by DEPTH, with a push/pop/level interface), and put decode and counting in priority_dec.

Verification
REQ-031 Reset check: assert rst=0 mid-stream with 3 entries queued -> D=0000, d_valid=0, level=0, count=0 at once; ready=1 one edge after release.
REQ-032 Decode sweep: push Y=11,10,01,00 with d_ready=1 -> D=0001,0010,0100,1000 in order, each one cycle after push; count=4.
REQ-033 Fill/backpressure: d_ready=0, push 5 codes with DEPTH=4 -> first 4 accepted, ready=0, level=4, fifth held on Y until a pop.
REQ-034 Simultaneous push/pop at level=2 -> level stays 2 and output order is preserved.
REQ-035 Wrap: 10 pushes and pops at DEPTH=4 -> pointers wrap with no loss or reorder; count goes 255->0 after 256 pops at CNT_W=8.
REQ-036 Loopback: the encoder output feeds priority_dec for all 15 nonzero D -> the decoded one-hot equals the highest-priority bit set in D.
